// File: rtl/stopwatch_controller_if.sv
// Signal bundle between the board buttons / tenth-second counter and the
// stopwatch sequencing controller.
interface stopwatch_controller_if;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clear;
  logic [13:0] count_in;
  logic        count_enable;
  logic        count_clear;
  logic [13:0] display;
  logic        running;
  logic        lap_active;
  logic        overflow;

  modport master (
    output btn_start, btn_lap, btn_clear, count_in,
    input  count_enable, count_clear, display, running, lap_active, overflow
  );

  modport slave (
    input  btn_start, btn_lap, btn_clear, count_in,
    output count_enable, count_clear, display, running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: debounces start/lap/clear, runs the IDLE/RUN/RUN_LAP/
// PAUSE/FULL state machine and drives counter enable/clear and the display.
module stopwatch_controller #(
  parameter int DEBOUNCE_TICKS = 1_000_000,
  parameter int MAX_COUNT      = 9999
) (
  input logic                   clk_i,
  input logic                   rst_i,
  stopwatch_controller_if.slave bus_io
);

  localparam int              CW     = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0]   RELOAD = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [13:0]     MAX_Q  = 14'(MAX_COUNT);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_RUN_LAP, S_PAUSE, S_FULL} state_t;

  // Button index: 0 = start, 1 = lap, 2 = clear
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d, deb_prev_q, strb_q;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  assign raw = {bus_io.btn_clear, bus_io.btn_lap, bus_io.btn_start};

  // Counter sits at RELOAD while the sync level matches the accepted level,
  // so any bounce back to the old level restarts the stability window.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = RELOAD;
      end else if (cnt_q[i] == '0) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = RELOAD;
      end else begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      strb_q     <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      strb_q     <= deb_q & ~deb_prev_q;
      cnt_q      <= cnt_d;
    end
  end

  logic st, lp, clr, at_max;
  assign st     = strb_q[0];
  assign lp     = strb_q[1];
  assign clr    = strb_q[2];
  assign at_max = (bus_io.count_in >= MAX_Q);

  state_t      state_q, state_d;
  logic [13:0] lap_q, lap_d, display_q, display_d;
  logic        count_enable_q, count_enable_d, count_clear_q, count_clear_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      lap_q          <= '0;
      display_q      <= '0;
      count_enable_q <= 1'b0;
      count_clear_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      lap_q          <= lap_d;
      display_q      <= display_d;
      count_enable_q <= count_enable_d;
      count_clear_q  <= count_clear_d;
    end
  end

  // Overflow beats every strobe; among strobes, the first valid one acts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (clr) state_d = S_IDLE;
                 else if (st) state_d = S_RUN;
      S_RUN:     if (at_max) state_d = S_FULL;
                 else if (st) state_d = S_PAUSE;
                 else if (lp) state_d = S_RUN_LAP;
      S_RUN_LAP: if (at_max) state_d = S_FULL;
                 else if (clr) state_d = S_RUN;
                 else if (st) state_d = S_PAUSE;
                 else if (lp) state_d = S_RUN_LAP;
      S_PAUSE:   if (clr) state_d = S_IDLE;
                 else if (st) state_d = S_RUN;
      S_FULL:    if (clr) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_enable_d = (state_d == S_RUN) || (state_d == S_RUN_LAP);
    count_clear_d  = clr && (state_d == S_IDLE);
    lap_d          = (lp && state_d == S_RUN_LAP) ? bus_io.count_in : lap_q;
    if (state_q == S_RUN_LAP)
      display_d = lap_q;
    else if (state_q == S_FULL && at_max)
      display_d = MAX_Q;
    else
      display_d = bus_io.count_in;
  end

  assign bus_io.count_enable = count_enable_q;
  assign bus_io.count_clear  = count_clear_q;
  assign bus_io.display      = display_q;
  assign bus_io.running      = (state_q == S_RUN) || (state_q == S_RUN_LAP);
  assign bus_io.lap_active   = (state_q == S_RUN_LAP);
  assign bus_io.overflow     = (state_q == S_FULL);

endmodule
